risc_core_mc: RTL and testbench

- Parametrised multi-cycle 16-bit-instruction RISC core. Successor to the fixed-width CPU top.
- Data width and memory address width are generic.
- Adds req/ack handshakes with wait-state support on both instruction and data memory, plus a halt state and a selectable debug register readout.
- Controller FSM and datapath (register file, A/B/ALU latches, PC) live in one block; memories are external.

---
 rtl/risc_core_mc.sv | 231 +++++++++++++++++++++++
 tb/tb_risc_core_mc.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_core_mc.sv
// -----------------------------------------------------------------------------
// risc_core_mc -- parametrised multi-cycle RISC core, 16-bit instructions.
//
// One FSM (FETCH/DECODE/EXEC/MEM/WB/HALT) drives a datapath holding an
// 8-entry register file (R0 reads 0), the instruction register, the A/B
// operand latches, the ALU result latch, the load-data latch and the PC.
// Instruction and data memories are external and use req/ack handshakes
// with any number of wait states.
//
// Parameters
//   DATA_W   : register / ALU / data-bus width (>= 8)
//   ADDR_W   : instruction and data address width, PC width
//   RESET_PC : PC value after reset
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous reset, ACTIVE-HIGH
//                         despite the name (kept for port-name consistency)
//   imem_req/addr/rdata/ack       : instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/rdata/ack : data load/store handshake
//   dbg_sel, dbg_reg_out : combinational read of R[dbg_sel]
//   halted              : core sits in HALT until reset
//   trap                : illegal-opcode trap, sticky until reset
//
// Build option
//   RISC_CORE_TRAP_EN : when defined, opcodes 0xB-0xE raise trap and halt with
//                       the PC left on the faulting instruction. When undefined
//                       they behave as NOP and trap stays 0.
// -----------------------------------------------------------------------------
module risc_core_mc #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_reg_out,
  output logic              halted,
  output logic              trap
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0, OP_ADD = 4'h1, OP_SUB  = 4'h2,
                         OP_AND  = 4'h3, OP_OR  = 4'h4, OP_XOR  = 4'h5,
                         OP_ADDI = 4'h6, OP_LD  = 4'h7, OP_ST   = 4'h8,
                         OP_BEQ  = 4'h9, OP_JMP = 4'hA, OP_HALT = 4'hF;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, ld_q, ld_d;
  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  logic              imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d, halted_q, halted_d, trap_q, trap_d;

  // Instruction fields, all taken from the latched IR.
  logic [3:0]        op;
  logic [2:0]        rd, rs1, rs2;
  logic [DATA_W-1:0] imm6_sx, alu_res;
  logic [ADDR_W-1:0] off6, off9, pc_inc;

  assign op      = ir_q[15:12];
  assign rd      = ir_q[11:9];
  assign rs1     = ir_q[8:6];
  assign rs2     = ir_q[5:3];
  // Size casts of a signed operand sign-extend the immediates.
  assign imm6_sx = DATA_W'($signed(ir_q[5:0]));
  assign off6    = ADDR_W'($signed(ir_q[5:0]));
  assign off9    = ADDR_W'($signed(ir_q[8:0]));
  assign pc_inc  = pc_q + 1'b1;

  always_comb begin
    case (op)
      OP_SUB:  alu_res = a_q - b_q;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      default: alu_res = a_q + b_q;  // ADD, ADDI and LD/ST address
    endcase
  end

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through the case
    // below leaves a variable unassigned, which would infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    ld_d       = ld_q;
    regs_d     = regs_q;
    imem_req_d = imem_req_q;
    dmem_req_d = dmem_req_q;
    dmem_we_d  = dmem_we_q;
    halted_d   = halted_q;
    trap_d     = trap_q;

    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d       = imem_rdata;
          imem_req_d = 1'b0;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d = regs_q[rs1];
        if (op == OP_ADDI || op == OP_LD || op == OP_ST) b_d = imm6_sx;
        else if (op == OP_BEQ)                           b_d = regs_q[rd];
        else                                             b_d = regs_q[rs2];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_d = alu_res;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: state_d = S_WB;
          OP_LD, OP_ST: begin
            dmem_req_d = 1'b1;
            dmem_we_d  = (op == OP_ST);
            state_d    = S_MEM;
          end
          OP_NOP, OP_BEQ, OP_JMP: begin
            if (op == OP_JMP)                     pc_d = pc_inc + off9;
            else if (op == OP_BEQ && a_q == b_q)  pc_d = pc_inc + off6;
            else                                  pc_d = pc_inc;
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: begin
`ifdef RISC_CORE_TRAP_EN
            trap_d   = 1'b1;
            halted_d = 1'b1;
            state_d  = S_HALT;
`else
            pc_d       = pc_inc;
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          if (op == OP_ST) begin
            pc_d       = pc_inc;
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
          end else begin
            ld_d    = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (rd != 3'd0) regs_d[rd] = (op == OP_LD) ? ld_q : alu_q;
        pc_d       = pc_inc;
        imem_req_d = 1'b1;
        state_d    = S_FETCH;
      end
      default: ;  // S_HALT: terminal until reset
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      alu_q      <= '0;
      ld_q       <= '0;
      // NOTE: the register file is flops, not RAM, and must read 0 after
      // reset, so it sits in the reset branch like any other state.
      regs_q     <= '{default: '0};
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      halted_q   <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      alu_q      <= alu_d;
      ld_q       <= ld_d;
      regs_q     <= regs_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dmem_we_q  <= dmem_we_d;
      halted_q   <= halted_d;
      trap_q     <= trap_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  // Low ADDR_W bits of the ALU latch; zero-extended when DATA_W < ADDR_W.
  assign dmem_addr   = ADDR_W'(alu_q);
  assign dmem_wdata  = regs_q[rd];
  assign dbg_reg_out = regs_q[dbg_sel];
  assign halted      = halted_q;
  assign trap        = trap_q;

endmodule

// File: tb/tb_risc_core_mc.sv
// Directed testbench for risc_core_mc (default parameters: 16-bit data and
// address, RESET_PC = 0). Memories are modelled here with programmable wait
// states; every expected value is hand-computed from the instruction encodings.
module tb_risc_core_mc;

  logic        clk;
  logic        rst_n;  // active-high reset
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [2:0]  dbg_sel;
  logic [15:0] dbg_reg_out;
  logic        halted, trap;

  risc_core_mc dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dbg_sel(dbg_sel), .dbg_reg_out(dbg_reg_out),
    .halted(halted), .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory models with wait states ----------------
  logic [15:0] imem [0:1023];
  logic [15:0] dmem [0:255];
  int imem_wait, dmem_wait, icnt, dcnt, cyc;

  assign imem_rdata = imem[imem_addr[9:0]];
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  assign imem_ack   = imem_req && (icnt == imem_wait);
  assign dmem_ack   = dmem_req && (dcnt == dmem_wait);

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      icnt <= 0; dcnt <= 0; cyc <= 0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
      cyc  <= cyc + 1;
      if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
    end
  end

  // ---------------- observation logs, sampled on the falling edge ----------
  logic [15:0] fetch_log[$], d_addr_log[$], d_wdata_log[$];
  logic        d_we_log[$];
  int          fetch_cyc[$];
  int          both_viol, we_viol, we_cycles;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (imem_req && dmem_req) both_viol++;
      if (dmem_we && !dmem_req) we_viol++;
      if (dmem_we) we_cycles++;
      if (imem_req && imem_ack) begin
        fetch_log.push_back(imem_addr);
        fetch_cyc.push_back(cyc);
      end
      if (dmem_req && dmem_ack) begin
        d_addr_log.push_back(dmem_addr);
        d_we_log.push_back(dmem_we);
        d_wdata_log.push_back(dmem_wdata);
      end
    end
  end

  int total, bad;

  // ---------------- sequencing helpers (no checking inside) ----------------
  task automatic begin_test();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
    for (int i = 0; i < 256; i++)  dmem[i] = 16'h0000;
    fetch_log.delete(); fetch_cyc.delete();
    d_addr_log.delete(); d_we_log.delete(); d_wdata_log.delete();
    we_cycles = 0; imem_wait = 0; dmem_wait = 0;
  endtask

  // Release between a rising and a falling edge; the next falling edge then
  // samples cycle 1.
  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
  endtask

  task automatic run_until_halted(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  task automatic read_reg(input int r, output logic [15:0] v);
    dbg_sel = 3'(r);
    #1 v = dbg_reg_out;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [15:0] v;
    begin_test();
    total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL rst_pc: got %h want 0000", imem_addr); end
    total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin bad++; $display("FAIL rst_dmem: got req=%b we=%b want 0 0", dmem_req, dmem_we); end
    total++; if (halted !== 1'b0 || trap !== 1'b0) begin bad++; $display("FAIL rst_flags: got halted=%b trap=%b want 0 0", halted, trap); end
    for (int r = 0; r < 8; r++) begin
      read_reg(r, v);
      total++; if (v !== 16'h0) begin bad++; $display("FAIL rst_reg%0d: got %h want 0000", r, v); end
    end
    release_reset();
    @(negedge clk);
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rst_first_req: got %b want 1", imem_req); end
  endtask

  // ADDI R1,R0,5; ADDI R2,R0,3; SUB R3,R1,R2; HALT -> 4+4+4+3 = 15 cycles
  task automatic test_alu_program();
    logic [15:0] v;
    begin_test();
    imem[0] = 16'h6205; imem[1] = 16'h6403; imem[2] = 16'h2650; imem[3] = 16'hF000;
    release_reset();
    @(negedge clk);
    repeat (14) @(negedge clk);
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early: got %b want 0 after 14 cycles", halted); end
    @(negedge clk);
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_at_15: got %b want 1", halted); end
    total++; if (imem_req !== 1'b0 || dmem_req !== 1'b0) begin bad++; $display("FAIL halt_req: got i=%b d=%b want 0 0", imem_req, dmem_req); end
    read_reg(3, v);
    total++; if (v !== 16'h0002) begin bad++; $display("FAIL sub_r3: got %h want 0002", v); end
    read_reg(1, v);
    total++; if (v !== 16'h0005) begin bad++; $display("FAIL addi_r1: got %h want 0005", v); end
    total++;
    if (fetch_log.size() != 4) begin
      bad++; $display("FAIL fetch_seq_len: got %0d want 4", fetch_log.size());
    end else if (fetch_log[0] !== 16'h0 || fetch_log[1] !== 16'h1 || fetch_log[2] !== 16'h2 || fetch_log[3] !== 16'h3) begin
      bad++; $display("FAIL fetch_seq: got %h %h %h %h want 0000 0001 0002 0003", fetch_log[0], fetch_log[1], fetch_log[2], fetch_log[3]);
    end
  endtask

  // All ALU ops, R0 write discard, not-taken BEQ, negative ADDI.
  task automatic test_alu_ops();
    logic [15:0] v;
    logic [15:0] exp_r [8];
    bit ok;
    begin_test();
    imem[0] = 16'h620C;  // ADDI R1,R0,12
    imem[1] = 16'h640A;  // ADDI R2,R0,10
    imem[2] = 16'h1650;  // ADD  R3,R1,R2 -> 0x16
    imem[3] = 16'h3850;  // AND  R4,R1,R2 -> 0x08
    imem[4] = 16'h4A50;  // OR   R5,R1,R2 -> 0x0E
    imem[5] = 16'h5C50;  // XOR  R6,R1,R2 -> 0x06
    imem[6] = 16'h1050;  // ADD  R0,R1,R2 -> discarded
    imem[7] = 16'h9285;  // BEQ  R1,R2,+5 -> not taken
    imem[8] = 16'h6E3E;  // ADDI R7,R0,-2 -> 0xFFFE
    imem[9] = 16'hF000;
    exp_r = '{16'h0, 16'h000C, 16'h000A, 16'h0016, 16'h0008, 16'h000E, 16'h0006, 16'hFFFE};
    release_reset();
    run_until_halted(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL alu_ops_timeout: got halted=%b want 1", halted); end
    for (int r = 0; r < 8; r++) begin
      read_reg(r, v);
      total++; if (v !== exp_r[r]) begin bad++; $display("FAIL alu_ops_r%0d: got %h want %h", r, v, exp_r[r]); end
    end
  endtask

  // 3 wait states on the fetch of ADDI R1,R0,-1: 4 + D + E + WB = 7 cycles.
  task automatic test_imem_wait();
    begin_test();
    imem[0] = 16'h623F;
    imem_wait = 3;
    dbg_sel = 3'd1;
    release_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0 || imem_ack !== (i == 3)) begin
        bad++; $display("FAIL iwait_c%0d: got req=%b addr=%h ack=%b want 1 0000 %b", i + 1, imem_req, imem_addr, imem_ack, i == 3);
      end
    end
    repeat (3) @(negedge clk);
    total++; if (dbg_reg_out !== 16'h0000) begin bad++; $display("FAIL iwait_r1_early: got %h want 0000", dbg_reg_out); end
    @(negedge clk);
    total++; if (dbg_reg_out !== 16'hFFFF) begin bad++; $display("FAIL iwait_r1: got %h want ffff", dbg_reg_out); end
  endtask

  // ADDI R1,R0,2; LD R2,R1,8; ST R2,R1,9; HALT with 2 data wait states.
  task automatic test_ld_st();
    logic [15:0] v;
    bit ok;
    begin_test();
    imem[0] = 16'h6202; imem[1] = 16'h7448; imem[2] = 16'h8449; imem[3] = 16'hF000;
    dmem[8'h0A] = 16'h1234;
    dmem_wait = 2;
    release_reset();
    run_until_halted(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL ldst_timeout: got halted=%b want 1", halted); end
    total++;
    if (d_addr_log.size() != 2) begin
      bad++; $display("FAIL ldst_count: got %0d want 2", d_addr_log.size());
    end else begin
      if (d_addr_log[0] !== 16'h000A || d_we_log[0] !== 1'b0) begin
        bad++; $display("FAIL ld_access: got addr=%h we=%b want 000a 0", d_addr_log[0], d_we_log[0]);
      end
      total++;
      if (d_addr_log[1] !== 16'h000B || d_we_log[1] !== 1'b1 || d_wdata_log[1] !== 16'h1234) begin
        bad++; $display("FAIL st_access: got addr=%h we=%b data=%h want 000b 1 1234", d_addr_log[1], d_we_log[1], d_wdata_log[1]);
      end
    end
    total++; if (dmem[8'h0B] !== 16'h1234) begin bad++; $display("FAIL st_mem: got %h want 1234", dmem[8'h0B]); end
    read_reg(2, v);
    total++; if (v !== 16'h1234) begin bad++; $display("FAIL ld_r2: got %h want 1234", v); end
    total++; if (we_cycles !== 3) begin bad++; $display("FAIL we_cycles: got %0d want 3", we_cycles); end
  endtask

  // NOPs at 0..3, BEQ R0,R0,-1 at 4: fetch addresses 0,1,2,3 then 4 every 3 cycles.
  task automatic test_branch();
    begin_test();
    imem[4] = 16'h903F;
    release_reset();
    repeat (30) @(negedge clk);
    total++;
    if (fetch_log.size() < 9) begin
      bad++; $display("FAIL beq_len: got %0d want >= 9", fetch_log.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        logic [15:0] exp_a;
        exp_a = (i < 4) ? 16'(i) : 16'h4;
        if (i > 0) total++;
        if (fetch_log[i] !== exp_a) begin bad++; $display("FAIL beq_addr%0d: got %h want %h", i, fetch_log[i], exp_a); end
      end
      for (int i = 5; i < 9; i++) begin
        total++;
        if (fetch_cyc[i] - fetch_cyc[i-1] != 3) begin bad++; $display("FAIL beq_period%0d: got %0d want 3", i, fetch_cyc[i] - fetch_cyc[i-1]); end
      end
    end
  endtask

  // JMP +0x0FF at 0x10 lands on 0x110, where a HALT waits.
  task automatic test_jmp();
    bit ok;
    begin_test();
    imem[16'h010] = 16'hA0FF;
    imem[16'h110] = 16'hF000;
    release_reset();
    run_until_halted(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL jmp_timeout: got halted=%b want 1", halted); end
    total++;
    if (fetch_log.size() != 18) begin
      bad++; $display("FAIL jmp_len: got %0d want 18", fetch_log.size());
    end else if (fetch_log[16] !== 16'h0010 || fetch_log[17] !== 16'h0110) begin
      bad++; $display("FAIL jmp_target: got %h -> %h want 0010 -> 0110", fetch_log[16], fetch_log[17]);
    end
  endtask

  // Reset asserted while a store waits for its ack.
  task automatic test_reset_mid_mem();
    logic [15:0] v;
    bit found;
    begin_test();
    imem[0] = 16'h6205;  // ADDI R1,R0,5
    imem[1] = 16'h8203;  // ST   R1,R0,3
    dmem[3] = 16'hAAAA;
    dmem_wait = 20;
    release_reset();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dmem_req) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_mem_reach: got dmem_req=%b want 1", dmem_req); end
    read_reg(1, v);
    total++; if (v !== 16'h0005) begin bad++; $display("FAIL mid_mem_r1: got %h want 0005", v); end
    rst_n = 1'b1;
    #1;
    total++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin bad++; $display("FAIL async_drop: got req=%b we=%b want 0 0", dmem_req, dmem_we); end
    total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL async_pc: got %h want 0000", imem_addr); end
    read_reg(1, v);
    total++; if (v !== 16'h0) begin bad++; $display("FAIL async_r1: got %h want 0000", v); end
    repeat (2) @(negedge clk);
    release_reset();
    @(negedge clk);
    total++; if (imem_req !== 1'b1 || dmem_req !== 1'b0) begin bad++; $display("FAIL post_rst_req: got i=%b d=%b want 1 0", imem_req, dmem_req); end
    total++; if (dmem[3] !== 16'hAAAA) begin bad++; $display("FAIL aborted_store: got %h want aaaa", dmem[3]); end
  endtask

  // Opcode 0xB at PC 0, HALT at PC 1.
  task automatic test_illegal();
    begin_test();
    imem[0] = 16'hB000;
    imem[1] = 16'hF000;
    release_reset();
    @(negedge clk);
    repeat (3) @(negedge clk);
`ifdef RISC_CORE_TRAP_EN
    total++; if (trap !== 1'b1 || halted !== 1'b1) begin bad++; $display("FAIL trap_set: got trap=%b halted=%b want 1 1", trap, halted); end
    total++; if (imem_addr !== 16'h0) begin bad++; $display("FAIL trap_pc: got %h want 0000", imem_addr); end
    repeat (3) @(negedge clk);
    total++; if (trap !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL trap_sticky: got trap=%b req=%b want 1 0", trap, imem_req); end
`else
    total++; if (trap !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL ill_nop: got trap=%b halted=%b want 0 0", trap, halted); end
    total++; if (imem_addr !== 16'h1) begin bad++; $display("FAIL ill_pc: got %h want 0001", imem_addr); end
    repeat (3) @(negedge clk);
    total++; if (halted !== 1'b1 || trap !== 1'b0) begin bad++; $display("FAIL ill_then_halt: got halted=%b trap=%b want 1 0", halted, trap); end
`endif
  endtask

  task automatic test_invariants();
    total++; if (both_viol !== 0) begin bad++; $display("FAIL req_overlap: got %0d cycles want 0", both_viol); end
    total++; if (we_viol !== 0) begin bad++; $display("FAIL we_without_req: got %0d cycles want 0", we_viol); end
  endtask

  initial begin
    rst_n = 1'b1;
    dbg_sel = 3'd0;
    total = 0; bad = 0;
    both_viol = 0; we_viol = 0; we_cycles = 0;
    imem_wait = 0; dmem_wait = 0;
    test_reset();
    test_alu_program();
    test_alu_ops();
    test_imem_wait();
    test_ld_st();
    test_branch();
    test_jmp();
    test_reset_mid_mem();
    test_illegal();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
